// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared types and constants for the Q-table row max scanner
package qlearn_pkg;

  localparam int N_STATES  = 36;
  localparam int N_ACTIONS = 4;
  localparam int N_ENTRIES = N_STATES * N_ACTIONS;
  localparam int Q_FRAC    = 24;
  localparam int EPSILON   = 26;

  typedef logic signed [31:0] q_t;
  typedef logic [1:0]         action_t;
  typedef logic [5:0]         state_t;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCAN,
    DONE
  } scan_state_e;

  function automatic logic row_ok(input state_t s);
    return s < state_t'(N_STATES);
  endfunction

endpackage

// File: rtl/qlearn_lfsr16.sv
// rtl/qlearn_lfsr16.sv - free-running 16-bit Fibonacci LFSR, built only with EPSILON_EXPLORE_EN
`ifdef EPSILON_EXPLORE_EN
module qlearn_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/q_row_max_scan.sv
// rtl/q_row_max_scan.sv - 36x4 Q-table with one-entry-per-cycle row max/argmax scan
// Optional epsilon-greedy exploration is enabled by defining EPSILON_EXPLORE_EN.
module q_row_max_scan
  import qlearn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  next_state,
  output logic        ready,
  output logic        valid,
  output logic [31:0] max_Q,
  output logic [1:0]  best_action,
  output logic        range_err,
  output logic        explore,
  input  logic        wr_en,
  output logic        wr_ready,
  input  logic [5:0]  wr_state,
  input  logic [1:0]  wr_action,
  input  logic [31:0] wr_data,
  input  logic [5:0]  rd_state,
  input  logic [1:0]  rd_action,
  output logic [31:0] rd_data
);

  localparam logic [7:0] CLR_LAST = 8'(N_ENTRIES - 1);

  scan_state_e state_q, state_d;
  logic [7:0]  clr_idx_q, clr_idx_d;
  state_t      row_q, row_d;
  action_t     idx_q, idx_d;
  q_t          run_max_q, run_max_d;
  action_t     run_best_q, run_best_d;
  q_t          max_q_q, max_q_d;
  action_t     best_q, best_d;
  logic        range_q, range_d;
  logic        explore_q, explore_d;
  logic        valid_q, valid_d;
  q_t          rd_data_q;

  q_t          q_tbl [N_STATES][N_ACTIONS];
  logic        tbl_we;
  state_t      tbl_row;
  action_t     tbl_col;
  q_t          tbl_wdata;
  q_t          entry;

`ifdef EPSILON_EXPLORE_EN
  logic [15:0] lfsr;

  qlearn_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );
`endif

  // Out-of-range rows read as zero so the scan naturally yields max 0 / action 0
  always_comb begin
    entry = '0;
    if (row_ok(row_q)) entry = q_tbl[row_q][idx_q];
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    row_d      = row_q;
    idx_d      = idx_q;
    run_max_d  = run_max_q;
    run_best_d = run_best_q;
    max_q_d    = max_q_q;
    best_d     = best_q;
    range_d    = range_q;
    explore_d  = explore_q;
    valid_d    = 1'b0;
    tbl_we     = 1'b0;
    tbl_row    = wr_state;
    tbl_col    = wr_action;
    tbl_wdata  = wr_data;

    case (state_q)
      CLEAR: begin
        tbl_we    = 1'b1;
        tbl_row   = clr_idx_q[7:2];
        tbl_col   = clr_idx_q[1:0];
        tbl_wdata = '0;
        clr_idx_d = clr_idx_q + 8'd1;
        if (clr_idx_q == CLR_LAST) state_d = IDLE;
      end
      IDLE: begin
        tbl_we = wr_en && row_ok(wr_state);
        if (start) begin
          row_d   = next_state;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // strict compare keeps the lowest action index on ties
        if (idx_q == 2'd0 || entry > run_max_q) begin
          run_max_d  = entry;
          run_best_d = idx_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        max_q_d   = run_max_q;
        best_d    = run_best_q;
        range_d   = !row_ok(row_q);
        explore_d = 1'b0;
`ifdef EPSILON_EXPLORE_EN
        if (row_ok(row_q) && lfsr[7:0] < 8'(EPSILON)) begin
          best_d    = lfsr[9:8];
          explore_d = 1'b1;
        end
`endif
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      run_max_q  <= '0;
      run_best_q <= '0;
      max_q_q    <= '0;
      best_q     <= '0;
      range_q    <= 1'b0;
      explore_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      run_max_q  <= run_max_d;
      run_best_q <= run_best_d;
      max_q_q    <= max_q_d;
      best_q     <= best_d;
      range_q    <= range_d;
      explore_q  <= explore_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) q_tbl[tbl_row][tbl_col] <= tbl_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_data_q <= '0;
    else if (row_ok(rd_state)) rd_data_q <= q_tbl[rd_state][rd_action];
    else                       rd_data_q <= '0;
  end

  assign ready       = (state_q == IDLE);
  assign wr_ready    = (state_q == IDLE);
  assign valid       = valid_q;
  assign max_Q       = max_q_q;
  assign best_action = best_q;
  assign range_err   = range_q;
  assign explore     = explore_q;
  assign rd_data     = rd_data_q;

endmodule
